// File: rtl/updown_counter_if.sv
// Control and status bundle for updown_counter; master drives controls, slave is the counter.
interface updown_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             i_srst;
   logic             i_cnt_en;
   logic             i_dir;
   logic             i_load_en;
   logic [WIDTH-1:0] i_load_data;
   logic [WIDTH-1:0] o_data;
   logic             o_tick;
   logic             o_borrow;
   logic             o_load_err;
   logic             o_at_max;
   logic             o_at_zero;

   modport master (
      output i_srst, i_cnt_en, i_dir, i_load_en, i_load_data,
      input  o_data, o_tick, o_borrow, o_load_err, o_at_max, o_at_zero
   );

   modport slave (
      input  i_srst, i_cnt_en, i_dir, i_load_en, i_load_data,
      output o_data, o_tick, o_borrow, o_load_err, o_at_max, o_at_zero
   );
endinterface

// File: rtl/updown_counter.sv
// Cascadable modulo 0..MAX_VAL counter with wrap/saturate, clamped load and carry/borrow ticks.
// Define UPDN_COUNTER_DOWN_EN to honour i_dir; otherwise the counter is up-only and o_borrow is 0.
module updown_counter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MAX_VAL = 9,
   parameter int unsigned WRAP    = 1
) (
   input logic           i_clk,
   input logic           i_rst,
   updown_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

   logic [WIDTH-1:0] data;
   logic             tick;
   logic             borrow;
   logic             load_err;
   logic [WIDTH-1:0] data_nxt;
   logic             tick_nxt;
   logic             borrow_nxt;
   logic             load_err_nxt;
   logic             down;

`ifdef UPDN_COUNTER_DOWN_EN
   assign down = bus.i_dir;
`else
   logic unused_dir;
   assign unused_dir = bus.i_dir;
   assign down       = 1'b0;
`endif

   // Priority: load, functional clear, count step; pulses default low.
   always_comb begin
      data_nxt     = data;
      tick_nxt     = 1'b0;
      borrow_nxt   = 1'b0;
      load_err_nxt = 1'b0;
      if (bus.i_load_en) begin
         if (bus.i_load_data > MAX_W) begin
            data_nxt     = MAX_W;
            load_err_nxt = 1'b1;
         end else begin
            data_nxt = bus.i_load_data;
         end
      end else if (bus.i_srst) begin
         data_nxt = '0;
      end else if (bus.i_cnt_en) begin
         if (!down) begin
            if (data == MAX_W) begin
               tick_nxt = 1'b1;
               if (WRAP != 0) data_nxt = '0;
            end else begin
               data_nxt = data + WIDTH'(1);
            end
         end else begin
            if (data == '0) begin
               borrow_nxt = 1'b1;
               if (WRAP != 0) data_nxt = MAX_W;
            end else begin
               data_nxt = data - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data     <= '0;
         tick     <= 1'b0;
         borrow   <= 1'b0;
         load_err <= 1'b0;
      end else begin
         data     <= data_nxt;
         tick     <= tick_nxt;
         borrow   <= borrow_nxt;
         load_err <= load_err_nxt;
      end
   end

   assign bus.o_data     = data;
   assign bus.o_tick     = tick;
   assign bus.o_borrow   = borrow;
   assign bus.o_load_err = load_err;
   assign bus.o_at_max   = (data == MAX_W);
   assign bus.o_at_zero  = (data == '0);
endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: wrapping and saturating counters (MAX_VAL=9) driven identically against a reference model.
module tb_updown_counter;
   localparam int MAXV = 9;
`ifdef UPDN_COUNTER_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] data;
      logic       tick;
      logic       borrow;
      logic       err;
      logic       at_max;
      logic       at_zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   updown_counter_if #(.WIDTH(4)) bus_w ();
   updown_counter_if #(.WIDTH(4)) bus_s ();

   updown_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP(1)) dut_w (.i_clk(clk), .i_rst(rst), .bus(bus_w));
   updown_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP(0)) dut_s (.i_clk(clk), .i_rst(rst), .bus(bus_s));

   exp_t qw[$];
   exp_t qs[$];
   int   mw = 0;
   int   ms = 0;
   int   n_total = 0;
   int   n_pass = 0;

   // Reference behaviour from the counting rules, using modular arithmetic on an int.
   function automatic exp_t model(inout int m, input bit wrap, input bit r, input bit s,
                                  input bit en, input bit dir, input bit ld, input int d);
      exp_t e;
      bit   dn;
      e  = '0;
      dn = dir & DOWN_EN;
      if (r) begin
         m = 0;
      end else if (ld) begin
         if (d > MAXV) begin
            m     = MAXV;
            e.err = 1'b1;
         end else begin
            m = d;
         end
      end else if (s) begin
         m = 0;
      end else if (en) begin
         if (!dn) begin
            if (m == MAXV) e.tick = 1'b1;
            m = wrap ? (m + 1) % (MAXV + 1) : ((m < MAXV) ? m + 1 : MAXV);
         end else begin
            if (m == 0) e.borrow = 1'b1;
            m = wrap ? (m + MAXV) % (MAXV + 1) : ((m > 0) ? m - 1 : 0);
         end
      end
      e.data    = 4'(m);
      e.at_max  = (m == MAXV);
      e.at_zero = (m == 0);
      return e;
   endfunction

   task automatic cyc(input bit r, input bit s, input bit en, input bit dir, input bit ld, input int d);
      @(negedge clk);
      rst               = r;
      bus_w.i_srst      = s;
      bus_w.i_cnt_en    = en;
      bus_w.i_dir       = dir;
      bus_w.i_load_en   = ld;
      bus_w.i_load_data = 4'(d);
      bus_s.i_srst      = s;
      bus_s.i_cnt_en    = en;
      bus_s.i_dir       = dir;
      bus_s.i_load_en   = ld;
      bus_s.i_load_data = 4'(d);
      qw.push_back(model(mw, 1'b1, r, s, en, dir, ld, d));
      qs.push_back(model(ms, 1'b0, r, s, en, dir, ld, d));
   endtask

   task automatic check(input string name, input exp_t act, input exp_t exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s t=%0t got data=%0d tick=%b borrow=%b err=%b max=%b zero=%b expected data=%0d tick=%b borrow=%b err=%b max=%b zero=%b",
                  name, $time, act.data, act.tick, act.borrow, act.err, act.at_max, act.at_zero,
                  exp.data, exp.tick, exp.borrow, exp.err, exp.at_max, exp.at_zero);
      else
         n_pass++;
   endtask

   // Monitor: the counters present a result every cycle; compare just after each edge.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         if (qw.size() > 0) begin
            e = qw.pop_front();
            a = {bus_w.o_data, bus_w.o_tick, bus_w.o_borrow, bus_w.o_load_err, bus_w.o_at_max, bus_w.o_at_zero};
            check("wrap", a, e);
         end
         if (qs.size() > 0) begin
            e = qs.pop_front();
            a = {bus_s.o_data, bus_s.o_tick, bus_s.o_borrow, bus_s.o_load_err, bus_s.o_at_max, bus_s.o_at_zero};
            check("sat", a, e);
         end
      end
   end

   initial begin
      bus_w.i_srst = 1'b0; bus_w.i_cnt_en = 1'b0; bus_w.i_dir = 1'b0;
      bus_w.i_load_en = 1'b0; bus_w.i_load_data = '0;
      bus_s.i_srst = 1'b0; bus_s.i_cnt_en = 1'b0; bus_s.i_dir = 1'b0;
      bus_s.i_load_en = 1'b0; bus_s.i_load_data = '0;

      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      repeat (12) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      repeat (12) cyc(0, 0, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 12);
      cyc(0, 0, 0, 0, 1, 5);
      cyc(0, 0, 0, 0, 1, 15);
      cyc(0, 0, 0, 0, 1, 9);
      cyc(0, 1, 1, 0, 1, 3);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 9);
      repeat (3) cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 1, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 6);
      cyc(1, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 500; i++) begin
         cyc($urandom_range(0, 49) == 0,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 15)));
      end

      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (qw.size() + qs.size() != 0)
         $display("FAIL drain got %0d pending expected 0", qw.size() + qs.size());
      else
         n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
